// File: rtl/dmem_resp.sv
// Word-addressed data memory responder with a valid/ready request and response handshake.
// Optional address checking is enabled by defining DMEM_RESP_ERR_CHECK_EN.
module dmem_resp #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nxt;

    logic               r_we;
    logic [IDX_W-1:0]   r_idx;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be;
    logic               r_err;

    logic [31:0]        r_rdata;
    logic               r_resp_err;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic               w_idle;
    logic               w_accept;
    logic               w_addr_err;
    logic               w_we;
    logic [IDX_W-1:0]   w_idx;
    logic [31:0]        w_wdata;
    logic [3:0]         w_be;
    logic               w_err;
    logic               w_enter_resp;
    logic               w_commit;
    logic               w_unused_addr;

`ifdef DMEM_RESP_ERR_CHECK_EN
    assign w_addr_err = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH_WORDS));
`else
    // Without checking, the byte offset and high address bits simply fall away.
    assign w_addr_err = 1'b0;
`endif
    assign w_unused_addr = ^{req_addr[31:IDX_W+2], req_addr[1:0]};

    assign w_idle     = (r_state == S_IDLE);
    assign w_accept   = req_valid && w_idle;
    assign req_ready  = w_idle;
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_resp_err;

    // With zero wait states the transaction completes on its accept edge, so use the live inputs.
    assign w_we    = w_idle ? req_we                   : r_we;
    assign w_idx   = w_idle ? req_addr[IDX_W+1:2]      : r_idx;
    assign w_wdata = w_idle ? req_wdata                : r_wdata;
    assign w_be    = w_idle ? req_be                   : r_be;
    assign w_err   = w_idle ? w_addr_err               : r_err;

    assign w_enter_resp = (w_state_nxt == S_RESP) && (r_state != S_RESP);
    assign w_commit     = w_enter_resp && w_we && !w_err && reset;

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches inferred.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= 32'd0;
            r_be       <= 4'd0;
            r_err      <= 1'b0;
            r_rdata    <= 32'd0;
            r_resp_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we    <= req_we;
                r_idx   <= req_addr[IDX_W+1:2];
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_err   <= w_addr_err;
            end
            if (w_enter_resp) begin
                r_rdata    <= (w_we || w_err) ? 32'd0 : r_mem[w_idx];
                r_resp_err <= w_err;
            end
        end
    end

    // NOTE: storage has no reset; its contents survive reset and it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: one instance with two wait states, one with none,
// each checked against a word-array model of the memory.
module tb_dmem_resp;

    localparam int DEPTH = 32;
    localparam int W_A   = 2;
    localparam int W_B   = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic [1:0]  v_req_valid;
    logic [1:0]  v_resp_ready;
    logic [1:0]  v_req_ready;
    logic [1:0]  v_resp_valid;
    logic [1:0]  v_resp_err;
    logic [31:0] v_rdata [2];

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem_m [2][DEPTH];
    logic [31:0] last_rdata;
    logic        last_err;

    always #5 clk = ~clk;

    dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W_A)) u_dut_a (
        .clk(clk), .reset(reset),
        .req_valid(v_req_valid[0]), .req_ready(v_req_ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(v_resp_valid[0]), .resp_ready(v_resp_ready[0]),
        .resp_rdata(v_rdata[0]), .resp_err(v_resp_err[0])
    );

    dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W_B)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(v_req_valid[1]), .req_ready(v_req_ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(v_resp_valid[1]), .resp_ready(v_resp_ready[1]),
        .resp_rdata(v_rdata[1]), .resp_err(v_resp_err[1])
    );

    function automatic int waits_of(input int s);
        return (s == 0) ? W_A : W_B;
    endfunction

    function automatic logic model_err(input logic [31:0] a);
`ifdef DMEM_RESP_ERR_CHECK_EN
        return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    // One full transaction on instance s; the model decides the expected response.
    task automatic do_txn(input int s, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int hold, input string name);
        logic [31:0] exp_d;
        logic        exp_e;
        int          idx;
        int          n;
        exp_e = model_err(addr);
        idx   = int'((addr >> 2) % DEPTH);
        exp_d = 32'd0;
        if (!exp_e) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem_m[s][idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                exp_d = mem_m[s][idx];
            end
        end

        @(negedge clk);
        checks++;
        if (v_req_ready[s] !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_ready: got %b want 1", name, v_req_ready[s]);
        end
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        v_req_valid[s] = 1'b1;
        @(posedge clk); #1;
        // Keep valid high with garbage: must be ignored outside IDLE and not recaptured.
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);

        n = 1;
        while (v_resp_valid[s] !== 1'b1 && n < 40) begin
            checks++;
            if (v_req_ready[s] !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_ready: got %b want 0", name, v_req_ready[s]);
            end
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (v_resp_valid[s] !== 1'b1 || n != waits_of(s) + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d edges (valid=%b) want %0d", name, n,
                     v_resp_valid[s], waits_of(s) + 1);
        end

        for (int h = 0; h < hold; h++) begin
            checks++;
            if (v_resp_valid[s] !== 1'b1 || v_rdata[s] !== exp_d ||
                v_resp_err[s] !== exp_e || v_req_ready[s] !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: valid=%b rdata=%h err=%b ready=%b want 1 %h %b 0",
                         name, h, v_resp_valid[s], v_rdata[s], v_resp_err[s], v_req_ready[s],
                         exp_d, exp_e);
            end
            @(posedge clk); #1;
        end

        checks++;
        if (v_rdata[s] !== exp_d || v_resp_err[s] !== exp_e) begin
            errors++;
            $display("FAIL %s resp: rdata=%h err=%b want %h %b", name, v_rdata[s],
                     v_resp_err[s], exp_d, exp_e);
        end
        last_rdata = v_rdata[s];
        last_err   = v_resp_err[s];

        v_req_valid[s]  = 1'b0;
        v_resp_ready[s] = 1'b1;
        @(posedge clk); #1;
        v_resp_ready[s] = 1'b0;
        checks++;
        if (v_resp_valid[s] !== 1'b0 || v_req_ready[s] !== 1'b1) begin
            errors++;
            $display("FAIL %s release: valid=%b ready=%b want 0 1", name,
                     v_resp_valid[s], v_req_ready[s]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
        v_req_valid = 2'b00; v_resp_ready = 2'b00;
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (v_resp_valid[s] !== 1'b0 || v_rdata[s] !== 32'd0 ||
                v_resp_err[s] !== 1'b0 || v_req_ready[s] !== 1'b1) begin
                errors++;
                $display("FAIL reset_state[%0d]: valid=%b rdata=%h err=%b ready=%b want 0 0 0 1",
                         s, v_resp_valid[s], v_rdata[s], v_resp_err[s], v_req_ready[s]);
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic init_mem();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++)
                do_txn(s, 1'b1, 32'(i * 4), 32'd0, 4'hF, 0, "init");
    endtask

    task automatic test_directed();
        do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "wr_10");
        checks++;
        if (last_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_10_err: got %b want 0", last_err);
        end
        do_txn(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, "rd_10");
        checks++;
        if (last_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_10_value: got %h want deadbeef", last_rdata);
        end
        do_txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, "wr_20_full");
        do_txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 0, "wr_20_be5");
        do_txn(0, 1'b1, 32'h20, 32'h55555555, 4'h0, 0, "wr_20_be0");
        do_txn(0, 1'b0, 32'h20, 32'd0, 4'h0, 0, "rd_20");
        checks++;
        if (last_rdata !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL rd_20_merge: got %h want 11bb33dd", last_rdata);
        end
    endtask

    task automatic test_backpressure();
        do_txn(0, 1'b0, 32'h10, 32'd0, 4'h0, 5, "bp_a");
        do_txn(1, 1'b0, 32'h04, 32'd0, 4'h0, 5, "bp_b");
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        v_req_valid[0] = 1'b1;
        @(posedge clk); #1;
        v_req_valid[0] = 1'b0;
        checks++;
        if (v_resp_valid[0] !== 1'b0 || v_req_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_entry: valid=%b ready=%b want 0 0",
                     v_resp_valid[0], v_req_ready[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (v_resp_valid[0] !== 1'b0 || v_rdata[0] !== 32'd0 ||
            v_resp_err[0] !== 1'b0 || v_req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_outputs: valid=%b rdata=%h err=%b ready=%b want 0 0 0 1",
                     v_resp_valid[0], v_rdata[0], v_resp_err[0], v_req_ready[0]);
        end
        @(negedge clk);
        reset = 1'b1;
        do_txn(0, 1'b0, 32'h40, 32'd0, 4'h0, 0, "rst_wait_rd40");
        checks++;
        if (last_rdata !== 32'd0) begin
            errors++;
            $display("FAIL rst_wait_no_commit: got %h want 00000000", last_rdata);
        end
    endtask

    task automatic test_addr_err();
        do_txn(0, 1'b1, 32'h42, 32'h12345678, 4'hF, 0, "err_wr42");
        do_txn(0, 1'b0, 32'h40, 32'd0, 4'h0, 0, "err_rd40");
        do_txn(0, 1'b0, 32'(DEPTH * 4), 32'd0, 4'h0, 0, "err_rd_oob");
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int t = 0; t < 40; t++) begin
            a = 32'($urandom_range(0, DEPTH + 7)) << 2;
            if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_0000);
            do_txn(int'($urandom_range(0, 1)), 1'($urandom), a, $urandom, 4'($urandom),
                   int'($urandom_range(0, 2)), "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [$];
        logic [31:0] a;
        logic [31:0] e;
        int          got;
        got = 0;
        req_we = 1'b0; req_be = 4'h0; req_wdata = 32'd0;
        v_resp_ready[1] = 1'b1;
        v_req_valid[1]  = 1'b1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            if (v_req_ready[1] === 1'b1) begin
                a = 32'($urandom_range(0, DEPTH - 1)) << 2;
                req_addr = a;
                exp_q.push_back(mem_m[1][int'(a >> 2)]);
            end
            @(posedge clk); #1;
            checks++;
            if (v_resp_valid[1] !== ((cyc % 2) == 0)) begin
                errors++;
                $display("FAIL b2b_cadence cyc%0d: valid=%b want %b", cyc, v_resp_valid[1],
                         (cyc % 2) == 0);
            end
            if (v_resp_valid[1] === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got++;
                checks++;
                if (v_rdata[1] !== e || v_resp_err[1] !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_data #%0d: rdata=%h err=%b want %h 0", got, v_rdata[1],
                             v_resp_err[1], e);
                end
            end
        end
        v_req_valid[1]  = 1'b0;
        v_resp_ready[1] = 1'b0;
        checks++;
        if (got != 12 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got %0d responses (%0d pending) want 12 (0)", got,
                     exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        init_mem();
        test_directed();
        test_backpressure();
        test_reset_in_wait();
        test_addr_err();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
